// File: rtl/ttl_ls161_counter.sv
// ttl_ls161_counter: cycle-accurate 74LS161 counter on a cen pseudo-clock (define LS161_SYNC_CLR_EN for 74LS163 synchronous clear)
module ttl_ls161_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         clr_n,
  input  logic         load_n,
  input  logic         enp,
  input  logic         ent,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         rco
);
  logic last_cen;
  logic cen_edge;
  logic clr_hit;
  assign cen_edge = cen & ~last_cen;
`ifdef LS161_SYNC_CLR_EN
  assign clr_hit = cen_edge & ~clr_n;
`else
  assign clr_hit = ~clr_n;
`endif
  assign rco = ent & (&q);
  // clear beats load beats count; last_cen tracks cen even while clearing
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= '0;
      last_cen <= 1'b1;
    end else begin
      last_cen <= cen;
      q        <= clr_hit                    ? '0 :
                  (cen_edge & ~load_n)       ? din :
                  (cen_edge & enp & ent)     ? q + 1'b1 : q;
    end
  end
endmodule

// File: tb/tb_ttl_ls161_counter.sv
// tb_ttl_ls161_counter: cascaded pair of counters checked against an integer model
module tb_ttl_ls161_counter;
  logic       clk = 0;
  logic       rst = 1, cen = 1, clr_n = 1, load_n = 1, enp = 1, ent = 1;
  logic [3:0] din_lo = 0, din_hi = 0;
  logic [3:0] q_lo, q_hi;
  logic       rco_lo, rco_hi;
  int         errors = 0, checks = 0;
  int         m_lo = 0, m_hi = 0;
  bit         m_last = 1;

  ttl_ls161_counter #(.W(4)) u_lo (.clk(clk), .rst(rst), .cen(cen), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(ent), .din(din_lo), .q(q_lo), .rco(rco_lo));
  ttl_ls161_counter #(.W(4)) u_hi (.clk(clk), .rst(rst), .cen(cen), .clr_n(clr_n), .load_n(load_n),
    .enp(enp), .ent(rco_lo), .din(din_hi), .q(q_hi), .rco(rco_hi));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("q_lo", {12'd0, q_lo}, 16'(m_lo));
    chk("q_hi", {12'd0, q_hi}, 16'(m_hi));
    chk("rco_lo", {15'd0, rco_lo}, 16'(ent && m_lo == 15));
    chk("rco_hi", {15'd0, rco_hi}, 16'(ent && m_lo == 15 && m_hi == 15));
  endtask

  task automatic step();
    bit e, c, ce_hi;
    @(posedge clk);
    if (rst) begin
      m_lo = 0; m_hi = 0; m_last = 1;
    end else begin
      e = cen && !m_last;
      m_last = cen;
      ce_hi = ent && m_lo == 15;
`ifdef LS161_SYNC_CLR_EN
      c = e && !clr_n;
`else
      c = !clr_n;
`endif
      m_hi = c ? 0 : (e && !load_n) ? int'(din_hi) : (e && enp && ce_hi) ? (m_hi + 1) % 16 : m_hi;
      m_lo = c ? 0 : (e && !load_n) ? int'(din_lo) : (e && enp && ent) ? (m_lo + 1) % 16 : m_lo;
    end
    #1;
    check_all();
  endtask

  task automatic pulse();
    cen = 0; step();
    cen = 1; step();
  endtask

  initial begin
    // reset with cen high, then cen held high: no edge
    step();
    chk("reset_q", {12'd0, q_lo}, 16'd0);
    rst = 0;
    for (int i = 0; i < 5; i++) step();
    chk("held_cen_q", {12'd0, q_lo}, 16'd0);
    pulse();
    chk("first_edge", {12'd0, q_lo}, 16'd1);
    // count to 15, rco gating by ent
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 15; i++) pulse();
    chk("q15", {12'd0, q_lo}, 16'd15);
    chk("rco15", {15'd0, rco_lo}, 16'd1);
    ent = 0; #1;
    chk("rco_ent0", {15'd0, rco_lo}, 16'd0);
    check_all();
    ent = 1; #1;
    pulse();
    chk("wrap", {12'd0, q_lo}, 16'd0);
    chk("wrap_rco", {15'd0, rco_lo}, 16'd0);
    // load ignores enp, then count
    load_n = 0; din_lo = 4'hA; enp = 0; pulse();
    chk("load", {12'd0, q_lo}, 16'd10);
    load_n = 1; enp = 1; pulse();
    chk("after_load", {12'd0, q_lo}, 16'd11);
    // clear with cen low
    load_n = 0; din_lo = 4'd7; pulse(); load_n = 1;
    cen = 0; step();
    clr_n = 0; step();
`ifdef LS161_SYNC_CLR_EN
    chk("clr_no_edge", {12'd0, q_lo}, 16'd7);
    cen = 1; step();
    chk("clr_edge", {12'd0, q_lo}, 16'd0);
`else
    chk("clr_async", {12'd0, q_lo}, 16'd0);
    cen = 1; step();
`endif
    // clear released with cen still high: edge lost
    clr_n = 1; step();
    chk("clr_release", {12'd0, q_lo}, 16'd0);
    // cascade 255 then 256
    rst = 1; step(); rst = 0;
    for (int i = 0; i < 255; i++) pulse();
    chk("casc_ff", {8'd0, q_hi, q_lo}, 16'h00FF);
    chk("casc_rco", {15'd0, rco_hi}, 16'd1);
    pulse();
    chk("casc_00", {8'd0, q_hi, q_lo}, 16'h0000);
    // reset mid-count beats load and edge
    load_n = 0; din_lo = 4'd9; pulse();
    chk("q9", {12'd0, q_lo}, 16'd9);
    cen = 0; step();
    cen = 1; rst = 1; step();
    chk("rst_mid", {12'd0, q_lo}, 16'd0);
    rst = 0; load_n = 1; step();
    chk("post_rst_hold", {12'd0, q_lo}, 16'd0);
    pulse();
    chk("post_rst_edge", {12'd0, q_lo}, 16'd1);
    // random
    for (int i = 0; i < 400; i++) begin
      cen    = 1'($urandom);
      clr_n  = ($urandom_range(0, 9) != 0);
      load_n = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 4) != 0);
      ent    = ($urandom_range(0, 4) != 0);
      din_lo = 4'($urandom);
      din_hi = 4'($urandom);
      rst    = ($urandom_range(0, 40) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
